// File: rtl/fp_to_fixed_decoder.sv
// -----------------------------------------------------------------------------
// fp_to_fixed_decoder
//
// Turns the 8-bit float format {sign, exp[EXP_W], sig[SIG_W]} back into
// OUT_W-bit two's-complement linear data:
//   value = (-1)^sign * sig * 2^exp
// Both sides use valid/ready handshakes. One word is in flight at a time.
//
// Default build: a serial shifter moves the significand one bit position
// per clock, so the result appears exp+1 cycles after the accept edge.
// Build option FP_DECODE_BARREL_EN: the SHIFT state is removed. The result
// is computed with a combinational barrel shift at the accept edge, so it
// appears one cycle after acceptance for every exponent. Both builds give
// bit-identical results.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   in_valid   sign/exp/sig carry a word
//   in_ready   decoder is idle and takes a word (depends only on state)
//   sign       1 = negative
//   exp        exponent, used as the shift count
//   sig        unsigned significand, no hidden bit
//   out_valid  d_out holds a decoded result
//   out_ready  downstream takes d_out
//   d_out      registered two's-complement result
//   busy       decoder is not idle
//
// Parameters: EXP_W, SIG_W, OUT_W. They must satisfy
// SIG_W + 2^EXP_W - 1 <= OUT_W - 1 so that the magnitude never overflows.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a word; in_ready high
// SHIFT | serial shift, cnt positions left to go (default build only)
// DONE  | result on d_out; held until out_ready
// -----------------------------------------------------------------------------
module fp_to_fixed_decoder #(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [EXP_W-1:0] exp,
  input  logic [SIG_W-1:0] sig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] d_out,
  output logic             busy
);

  // The magnitude gets one bit less than the output; the top bit is the sign.
  localparam int MAG_W = OUT_W - 1;

`ifdef FP_DECODE_BARREL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  state_t           state, state_nxt;
  logic [OUT_W-1:0] d_out_nxt;
  logic             out_valid_nxt;

  // Applies the sign to a magnitude. A negative zero becomes zero because
  // the carry out of ~0 + 1 falls off the top.
  function automatic logic [OUT_W-1:0] apply_sign(input logic             neg,
                                                  input logic [MAG_W-1:0] m);
    logic [OUT_W-1:0] ext;
    ext = {1'b0, m};
    return neg ? (~ext + OUT_W'(1)) : ext;
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

`ifdef FP_DECODE_BARREL_EN

  always_comb begin
    state_nxt     = state;
    d_out_nxt     = d_out;
    out_valid_nxt = out_valid;
    case (state)
      IDLE: begin
        if (in_valid) begin
          d_out_nxt     = apply_sign(sign, MAG_W'(sig) << exp);
          out_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: begin
        out_valid_nxt = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      d_out     <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= out_valid_nxt;
      d_out     <= d_out_nxt;
    end
  end

`else

  logic [MAG_W-1:0] mag, mag_nxt;
  logic [EXP_W-1:0] cnt, cnt_nxt;
  logic             sgn, sgn_nxt;

  always_comb begin
    state_nxt     = state;
    d_out_nxt     = d_out;
    out_valid_nxt = out_valid;
    mag_nxt       = mag;
    cnt_nxt       = cnt;
    sgn_nxt       = sgn;
    case (state)
      IDLE: begin
        if (in_valid) begin
          mag_nxt   = MAG_W'(sig);
          cnt_nxt   = exp;
          sgn_nxt   = sign;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          mag_nxt = mag << 1;
          cnt_nxt = cnt - EXP_W'(1);
        end else begin
          d_out_nxt     = apply_sign(sgn, mag);
          out_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: begin
        out_valid_nxt = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      d_out     <= '0;
      mag       <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= out_valid_nxt;
      d_out     <= d_out_nxt;
      mag       <= mag_nxt;
      cnt       <= cnt_nxt;
      sgn       <= sgn_nxt;
    end
  end

`endif

endmodule
